// File: rtl/serial_mult_pkg.sv
// rtl/serial_mult_pkg.sv - shared types and width helpers for the serial multiplier
package serial_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        MULT = 2'd2,
        SEND = 2'd3
    } state_e;

    // Bit counter must reach 2*w-1 during SEND
    function automatic int cnt_width(input int w);
        return $clog2(2 * w) + 1;
    endfunction

endpackage

// File: rtl/serial_mult_core.sv
// rtl/serial_mult_core.sv - iterative shift-add/subtract engine, one partial product per cycle
module serial_mult_core
    import serial_mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               start_i,
    input  logic               sgn_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] prod_o
);

    localparam int PW    = 2 * WIDTH;
    localparam int IDX_W = $clog2(WIDTH);

    logic [PW-1:0]    acc_q, acc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [IDX_W-1:0] idx_cur;
    logic [PW-1:0]    acc_base, a_ext, pp, sum;
    logic             last;

    // The start cycle already folds in partial product 0
    always_comb begin
        idx_cur  = start_i ? '0 : idx_q;
        acc_base = start_i ? '0 : acc_q;
        a_ext    = sgn_i ? {{WIDTH{a_i[WIDTH-1]}}, a_i} : {{WIDTH{1'b0}}, a_i};
        pp       = b_i[idx_cur] ? (a_ext << idx_cur) : '0;
        last     = (idx_cur == IDX_W'(WIDTH - 1));
        sum      = (sgn_i && last) ? (acc_base - pp) : (acc_base + pp);

        acc_d  = acc_q;
        idx_d  = idx_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start_i || busy_q) begin
            acc_d  = sum;
            idx_d  = idx_cur + IDX_W'(1);
            busy_d = !last;
            done_d = last;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            acc_q  <= '0;
            idx_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            idx_q  <= idx_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign done_o = done_q;
    assign prod_o = acc_q;

endmodule

// File: rtl/serial_mult_param.sv
// rtl/serial_mult_param.sv - bit-serial multiplier: operand capture, FSM, product serialiser
module serial_mult_param
    import serial_mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic IN_START,
    input  logic A,
    input  logic B,
    input  logic SGN,
    output logic IN_READY,
    output logic O,
    output logic O_VALID,
    input  logic O_READY,
    output logic O_LAST
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam int PW    = 2 * WIDTH;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             sgn_q, sgn_d;
    logic             start_q, start_d;
    logic [PW-1:0]    sh_q, sh_d;
    logic             o_q, o_d, o_valid_q, o_valid_d, o_last_q, o_last_d;
    logic             in_ready_q, in_ready_d;
    logic             core_done;
    logic [PW-1:0]    core_prod;

    serial_mult_core #(.WIDTH(WIDTH)) u_core (
        .clk_i   (CLK),
        .rstn_i  (RST),
        .start_i (start_q),
        .sgn_i   (sgn_q),
        .a_i     (a_q),
        .b_i     (b_q),
        .done_o  (core_done),
        .prod_o  (core_prod)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        sgn_d      = sgn_q;
        start_d    = 1'b0;
        sh_d       = sh_q;
        o_d        = o_q;
        o_valid_d  = o_valid_q;
        o_last_d   = o_last_q;
        in_ready_d = in_ready_q;
        case (state_q)
            IDLE: begin
                if (IN_START) begin
                    a_d        = {A, a_q[WIDTH-1:1]};
                    b_d        = {B, b_q[WIDTH-1:1]};
                    sgn_d      = SGN;
                    cnt_d      = CNT_W'(1);
                    in_ready_d = 1'b0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                // LSB-first shift-in leaves bit 0 at position 0 after WIDTH edges
                a_d = {A, a_q[WIDTH-1:1]};
                b_d = {B, b_q[WIDTH-1:1]};
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    start_d = 1'b1;
                    state_d = MULT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            MULT: begin
                if (core_done) begin
                    sh_d      = core_prod >> 1;
                    o_d       = core_prod[0];
                    o_valid_d = 1'b1;
                    o_last_d  = 1'b0;
                    cnt_d     = '0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (O_READY) begin
                    if (cnt_q == CNT_W'(PW - 1)) begin
                        o_d        = 1'b0;
                        o_valid_d  = 1'b0;
                        o_last_d   = 1'b0;
                        in_ready_d = 1'b1;
                        cnt_d      = '0;
                        state_d    = IDLE;
                    end else begin
                        o_d      = sh_q[0];
                        sh_d     = sh_q >> 1;
                        o_last_d = (cnt_q == CNT_W'(PW - 2));
                        cnt_d    = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            sgn_q      <= 1'b0;
            start_q    <= 1'b0;
            sh_q       <= '0;
            o_q        <= 1'b0;
            o_valid_q  <= 1'b0;
            o_last_q   <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sgn_q      <= sgn_d;
            start_q    <= start_d;
            sh_q       <= sh_d;
            o_q        <= o_d;
            o_valid_q  <= o_valid_d;
            o_last_q   <= o_last_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign IN_READY = in_ready_q;
    assign O        = o_q;
    assign O_VALID  = o_valid_q;
    assign O_LAST   = o_last_q;

endmodule

// File: tb/tb_serial_mult_param.sv
// tb/tb_serial_mult_param.sv - directed-vector bench for serial_mult_param at WIDTH=4
module tb_serial_mult_param;

    logic CLK = 1'b0;
    logic RST, IN_START, A, B, SGN, O_READY;
    logic IN_READY, O, O_VALID, O_LAST;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int start_cyc = 0;

    serial_mult_param #(.WIDTH(4)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .IN_START (IN_START),
        .A        (A),
        .B        (B),
        .SGN      (SGN),
        .IN_READY (IN_READY),
        .O        (O),
        .O_VALID  (O_VALID),
        .O_READY  (O_READY),
        .O_LAST   (O_LAST)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the last operand edge
    task automatic send_ops(input logic [3:0] a, input logic [3:0] b, input logic sgn,
                            input logic glitch);
        int g = 0;
        while (!IN_READY && g < 50) begin
            @(negedge CLK);
            g++;
        end
        check("in_ready_before_start", IN_READY, 1);
        IN_START  = 1'b1;
        A         = a[0];
        B         = b[0];
        SGN       = sgn;
        start_cyc = cyc + 1;
        for (int k = 1; k < 4; k++) begin
            @(negedge CLK);
            IN_START = glitch && (k == 1);
            A        = a[k];
            B        = b[k];
            SGN      = ~sgn;
        end
        @(negedge CLK);
        IN_START = 1'b0;
        A        = 1'b1;
        B        = 1'b1;
    endtask

    task automatic recv(input logic [7:0] exp, input int stall_j, input int stall_len,
                        input string tag);
        int g = 0;
        int j = 0;
        int stl = stall_len;
        logic [7:0] got = 8'h00;
        while (!O_VALID && g < 40) begin
            @(negedge CLK);
            g++;
        end
        check({tag, "_latency"}, cyc - start_cyc, 8);
        g = 0;
        while (j < 8 && g < 60) begin
            got[j] = O;
            if (j == stall_j && stl > 0) begin
                O_READY = 1'b0;
                check({tag, "_hold_o"}, O, exp[j]);
                check({tag, "_hold_valid"}, O_VALID, 1);
                stl--;
            end else begin
                O_READY = 1'b1;
                check({tag, "_last"}, O_LAST, (j == 7));
                j++;
            end
            @(negedge CLK);
            g++;
        end
        O_READY = 1'b1;
        check({tag, "_bits"}, j, 8);
        check({tag, "_product"}, got, exp);
        check({tag, "_valid_after"}, O_VALID, 0);
        check({tag, "_ready_after"}, IN_READY, 1);
    endtask

    initial begin
        int seen;
        RST      = 1'b0;
        IN_START = 1'b0;
        A        = 1'b0;
        B        = 1'b0;
        SGN      = 1'b0;
        O_READY  = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_o", O, 0);
        check("rst_valid", O_VALID, 0);
        check("rst_last", O_LAST, 0);
        check("rst_in_ready", IN_READY, 1);
        RST = 1'b1;
        @(negedge CLK);

        // Second frame starts the very cycle IN_READY rises
        send_ops(4'd13, 4'd11, 1'b0, 1'b0);
        recv(8'h8F, -1, 0, "u13x11");
        send_ops(4'hD, 4'h5, 1'b1, 1'b0);
        recv(8'hF1, -1, 0, "s_m3x5");

        send_ops(4'h8, 4'h8, 1'b1, 1'b0);
        recv(8'h40, -1, 0, "s_m8xm8");
        send_ops(4'hF, 4'hF, 1'b0, 1'b0);
        recv(8'hE1, -1, 0, "u15x15");
        send_ops(4'h8, 4'h7, 1'b1, 1'b0);
        recv(8'hC8, -1, 0, "s_m8x7");
        send_ops(4'h7, 4'hF, 1'b1, 1'b0);
        recv(8'hF9, -1, 0, "s_7xm1");

        send_ops(4'd6, 4'd7, 1'b0, 1'b0);
        recv(8'h2A, 2, 3, "stall_6x7");

        send_ops(4'd7, 4'd9, 1'b0, 1'b1);
        recv(8'h3F, -1, 0, "glitch_7x9");

        send_ops(4'd9, 4'd9, 1'b0, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        check("midrst_valid", O_VALID, 0);
        check("midrst_in_ready", IN_READY, 1);
        check("midrst_last", O_LAST, 0);
        seen = 0;
        repeat (12) begin
            @(negedge CLK);
            if (O_VALID) seen++;
        end
        check("midrst_no_output", seen, 0);
        send_ops(4'd2, 4'd3, 1'b0, 1'b0);
        recv(8'h06, -1, 0, "after_rst_2x3");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
